route_request_ctrl: RTL and testbench

- Per-input-VC client of the router's route-computation stage.
- Captures a head flit's destination and raises a route-computation request with that destination.
- Latches the returned preferred-route vector on grant, then adaptively selects one productive output port based on downstream credit availability.
- Requests that port from the switch/VC allocator, locks the selection, and holds it until the packet's tail flit departs.
- One instance sits in each input unit, on the opposite side of the rc_req/rc_gnt/g_route handshake from the shared route engine.

---
 rtl/noc_route_pkg.sv | 31 +++
 rtl/route_port_sel.sv | 24 ++
 rtl/route_request_ctrl.sv | 83 ++++++++
 tb/tb_route_request_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/noc_route_pkg.sv
// noc_route_pkg: shared port indices, route-client state encoding and route-field decode.
package noc_route_pkg;
    localparam int P_LOCAL = 0;
    localparam int P_XPOS  = 1;
    localparam int P_XNEG  = 2;
    localparam int P_YPOS  = 3;
    localparam int P_YNEG  = 4;
    localparam logic [4:0] L_MASK = 5'b00001;
    localparam logic [4:0] X_MASK = 5'b00110;
    localparam logic [4:0] Y_MASK = 5'b11000;

    typedef enum logic [1:0] {IDLE, RC_WAIT, SEL, ACTIVE} state_t;

    typedef struct packed {
        logic [4:0] prod;
        logic       illegal;
    } route_dec_t;

    // An 11 field is illegal and behaves as "no hop" in that dimension.
    function automatic route_dec_t route_decode(input logic [1:0] x, input logic [1:0] y);
        route_dec_t d;
        d.prod          = '0;
        d.prod[P_XPOS]  = x == 2'b01;
        d.prod[P_XNEG]  = x == 2'b10;
        d.prod[P_YPOS]  = y == 2'b01;
        d.prod[P_YNEG]  = y == 2'b10;
        d.prod[P_LOCAL] = (x == 2'b00 || x == 2'b11) && (y == 2'b00 || y == 2'b11);
        d.illegal       = x == 2'b11 || y == 2'b11;
        return d;
    endfunction
endpackage

// File: rtl/route_port_sel.sv
// route_port_sel: picks one credited productive port, breaking X/Y ties with pref_y.
module route_port_sel
    import noc_route_pkg::*;
(
    input  logic [4:0] prod,
    input  logic [4:0] credit,
    input  logic       pref_y,
    output logic [4:0] out_req,
    output logic       both_xy
);
    logic [4:0] elig;
    logic       x_ok;
    logic       y_ok;

    // At most one port per dimension is productive, so masking yields one-hot.
    always_comb begin
        elig    = prod & credit;
        x_ok    = elig[P_XPOS] | elig[P_XNEG];
        y_ok    = elig[P_YPOS] | elig[P_YNEG];
        both_xy = x_ok & y_ok;
        out_req = elig[P_LOCAL] ? (elig & L_MASK) :
                  (y_ok && (!x_ok || pref_y)) ? (elig & Y_MASK) : (elig & X_MASK);
    end
endmodule

// File: rtl/route_request_ctrl.sv
// route_request_ctrl: per-VC route-computation client with adaptive output port selection,
// locking the chosen port from allocator grant until the packet tail departs.
module route_request_ctrl
    import noc_route_pkg::*;
#(
    parameter int DEST_BITS = 4,
    parameter int PORTS     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hd_valid,
    input  logic [DEST_BITS-1:0] hd_dest,
    output logic                 rc_req,
    output logic [DEST_BITS-1:0] rc_dest,
    input  logic                 rc_gnt,
    input  logic [DEST_BITS-1:0] g_route,
    input  logic [PORTS-1:0]     out_credit,
    output logic [PORTS-1:0]     out_req,
    input  logic                 out_gnt,
    output logic [PORTS-1:0]     out_port,
    input  logic                 flit_fire,
    input  logic                 flit_tail,
    output logic                 route_err
);
    localparam int H = DEST_BITS / 2;

    state_t               state;
    logic [DEST_BITS-1:0] route_q;
    logic                 pref_y;
    route_dec_t           dec;
    logic [PORTS-1:0]     sel_req;
    logic                 both_xy;

    assign dec     = route_decode(route_q[1:0], route_q[H +: 2]);
    assign out_req = (state == SEL) ? sel_req : '0;

    route_port_sel u_sel (
        .prod    (dec.prod),
        .credit  (out_credit),
        .pref_y  (pref_y),
        .out_req (sel_req),
        .both_xy (both_xy)
    );

    // rc_dest doubles as the captured head destination.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rc_req    <= 1'b0;
            rc_dest   <= '0;
            route_q   <= '0;
            out_port  <= '0;
            pref_y    <= 1'b0;
            route_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hd_valid) begin
                    rc_dest <= hd_dest;
                    rc_req  <= 1'b1;
                    state   <= RC_WAIT;
                end
                RC_WAIT: if (rc_gnt) begin
                    route_q <= g_route;
                    rc_req  <= 1'b0;
                    state   <= SEL;
                end
                SEL: begin
                    route_err <= route_err | dec.illegal;
                    if (out_gnt && |out_req) begin
                        out_port <= out_req;
                        pref_y   <= pref_y ^ both_xy;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: if (flit_fire && flit_tail) begin
                    out_port <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_route_request_ctrl.sv
// tb_route_request_ctrl: directed and randomized packets checked against a packet-level model.
module tb_route_request_ctrl;
    logic       clk = 0, rst = 1, hd_valid = 0, rc_gnt = 0, out_gnt = 0, flit_fire = 0, flit_tail = 0;
    logic [3:0] hd_dest = '0, g_route = '0;
    logic [4:0] out_credit = '0;
    logic       rc_req, route_err;
    logic [3:0] rc_dest;
    logic [4:0] out_req, out_port;
    int         errors = 0, checks = 0;
    bit         m_pref = 0, m_err = 0;

    always #5 clk = ~clk;

    route_request_ctrl dut (
        .clk(clk), .rst(rst), .hd_valid(hd_valid), .hd_dest(hd_dest), .rc_req(rc_req),
        .rc_dest(rc_dest), .rc_gnt(rc_gnt), .g_route(g_route), .out_credit(out_credit),
        .out_req(out_req), .out_gnt(out_gnt), .out_port(out_port), .flit_fire(flit_fire),
        .flit_tail(flit_tail), .route_err(route_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int port_of(input logic [1:0] f, input int pos);
        return f == 2'b01 ? pos : f == 2'b10 ? pos + 1 : -1;
    endfunction

    function automatic bit illegal(input logic [3:0] r);
        return r[1:0] == 2'b11 || r[3:2] == 2'b11;
    endfunction

    // Expected request: which productive ports have credit, tie broken by the preference.
    function automatic logic [4:0] model_sel(input logic [3:0] r, input logic [4:0] cr,
                                             input bit pref, output bit both);
        int xp, yp;
        bit xe, ye;
        xp = port_of(r[1:0], 1);
        yp = port_of(r[3:2], 3);
        xe = xp >= 0 && cr[xp];
        ye = yp >= 0 && cr[yp];
        both = xe && ye;
        if (xp < 0 && yp < 0) return cr[0] ? 5'b00001 : 5'b00000;
        if (ye && (!xe || pref)) return 5'b00001 << yp;
        if (xe) return 5'b00001 << xp;
        return 5'b00000;
    endfunction

    task automatic packet(input logic [3:0] dest, input logic [3:0] route, input int rc_delay,
                          input int starve, input int n_rand, input logic [4:0] final_cred,
                          input int body, input bit abort);
        logic [4:0] exp, port;
        bit both;
        check("idle_rc_req", rc_req, 0);
        check("idle_port", out_port, 0);
        hd_valid = 1;
        hd_dest  = dest;
        @(negedge clk);
        for (int i = 0; i <= rc_delay; i++) begin
            check("rc_req", rc_req, 1);
            check("rc_dest", rc_dest, dest);
            check("rcw_out_req", out_req, 0);
            hd_valid = 1'($urandom_range(0, 1));
            hd_dest  = 4'($urandom);
            rc_gnt   = (i == rc_delay);
            g_route  = (i == rc_delay) ? route : 4'($urandom);
            @(negedge clk);
        end
        rc_gnt   = 0;
        hd_valid = 0;
        g_route  = 4'($urandom);
        for (int i = 0; i < starve + n_rand; i++) begin
            out_credit = (i < starve) ? 5'b00000 : 5'($urandom);
            #1;
            exp = model_sel(route, out_credit, m_pref, both);
            check("sel_req", out_req, exp);
            check("sel_rc_req", rc_req, 0);
            out_gnt = (exp == 0) && (i < starve || $urandom_range(0, 1) == 1);
            @(negedge clk);
            out_gnt = 0;
        end
        out_credit = final_cred;
        #1;
        exp = model_sel(route, out_credit, m_pref, both);
        check("sel_req_final", out_req, exp);
        out_gnt = 1;
        @(negedge clk);
        out_gnt = 0;
        if (both) m_pref = !m_pref;
        m_err |= illegal(route);
        port = exp;
        check("route_err", route_err, m_err);
        check("act_port", out_port, port);
        check("act_req", out_req, 0);
        for (int i = 0; i < body; i++) begin
            flit_fire = 1'($urandom_range(0, 1));
            flit_tail = !flit_fire && $urandom_range(0, 1) == 1;
            rc_gnt    = 1'($urandom_range(0, 1));
            out_gnt   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_port", out_port, port);
            check("hold_req", out_req, 0);
        end
        rc_gnt  = 0;
        out_gnt = 0;
        if (abort) begin
            flit_fire = 0;
            flit_tail = 0;
            rst = 1;
            @(negedge clk);
            rst = 0;
            m_pref = 0;
            m_err = 0;
            check("rst_port", out_port, 0);
            check("rst_rc_req", rc_req, 0);
            check("rst_err", route_err, 0);
            check("rst_rc_dest", rc_dest, 0);
        end else begin
            flit_fire = 1;
            flit_tail = 1;
            @(negedge clk);
            flit_fire = 0;
            flit_tail = 0;
            check("tail_port", out_port, 0);
            check("tail_rc_req", rc_req, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_rc_req", rc_req, 0);
        check("reset_rc_dest", rc_dest, 0);
        check("reset_out_req", out_req, 0);
        check("reset_out_port", out_port, 0);
        check("reset_err", route_err, 0);
        rst = 0;
        packet(4'h5, 4'b0001, 0, 0, 0, 5'b11111, 0, 0);
        packet(4'h3, 4'b0000, 0, 0, 0, 5'b11111, 0, 0);
        packet(4'h9, 4'b1001, 0, 0, 0, 5'b11111, 1, 0);
        packet(4'h9, 4'b1001, 1, 0, 0, 5'b11111, 2, 0);
        packet(4'h9, 4'b1001, 0, 3, 0, 5'b10000, 0, 0);
        packet(4'h3, 4'b0011, 0, 0, 0, 5'b11111, 1, 0);
        for (int n = 0; n < 30; n++)
            packet(4'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 4), 5'b11111, $urandom_range(0, 3), 0);
        check("err_sticky", route_err, 1);
        packet(4'h4, 4'b0100, 0, 0, 0, 5'b11111, 2, 1);
        rc_gnt = 1;
        @(negedge clk);
        rc_gnt = 0;
        @(negedge clk);
        check("stray_gnt_rc_req", rc_req, 0);
        check("stray_gnt_out_req", out_req, 0);
        check("stray_gnt_port", out_port, 0);
        packet(4'h6, 4'b1001, 0, 0, 0, 5'b11111, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
